// File: rtl/imm_extend_pipe_if.sv
// Handshake/data bundle between decode and execute for imm_extend_pipe.
// slave = the extender, master = the environment driving and consuming it.
interface imm_extend_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            ImmSrc;
    logic [31:0]           instr;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ImmExt;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  imm_err;

    modport slave (
        input  in_valid, ImmSrc, instr, in_tag, out_ready,
        output in_ready, out_valid, ImmExt, out_tag, imm_err
    );

    modport master (
        output in_valid, ImmSrc, instr, in_tag, out_ready,
        input  in_ready, out_valid, ImmExt, out_tag, imm_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined RV32/RV64 immediate extender: main output register plus one skid entry.
// Optional IMM_ERR_COUNT_EN adds a saturating 16-bit count of accepted illegal ImmSrc.
module imm_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    imm_extend_pipe_if.slave    bus
`ifdef IMM_ERR_COUNT_EN
    ,
    output logic [15:0]         err_count
`endif
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("imm_extend_pipe: DATA_WIDTH must be 32 or 64");
    end

    logic [31:0]           imm32;
    logic                  sext;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] dec_imm;

    // Every format fits in 32 bits; widening to 64 is a single signed/unsigned cast.
    always_comb begin
        imm32   = 32'd0;
        sext    = 1'b1;
        dec_err = 1'b0;
        unique case (bus.ImmSrc)
            3'b000: imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
            3'b001: imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            3'b010: imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                             bus.instr[30:25], bus.instr[11:8], 1'b0};
            3'b011: imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                             bus.instr[20], bus.instr[30:21], 1'b0};
            3'b100: imm32 = {bus.instr[31:12], 12'b0};
            3'b101: begin
                sext  = 1'b0;
                imm32 = (DATA_WIDTH == 64) ? {26'd0, bus.instr[25:20]}
                                           : {27'd0, bus.instr[24:20]};
            end
            3'b110: begin
                sext  = 1'b0;
                imm32 = {27'd0, bus.instr[19:15]};
            end
            default: begin
                sext    = 1'b0;
                dec_err = 1'b1;
            end
        endcase
        dec_imm = sext ? DATA_WIDTH'($signed(imm32)) : DATA_WIDTH'(imm32);
    end

    logic unused_opcode;
    assign unused_opcode = ^bus.instr[6:0];

    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_imm_q,   main_imm_d;
    logic [TAG_WIDTH-1:0]  main_tag_q,   main_tag_d;
    logic                  main_err_q,   main_err_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_imm_q,   skid_imm_d;
    logic [TAG_WIDTH-1:0]  skid_tag_q,   skid_tag_d;
    logic                  skid_err_q,   skid_err_d;

    logic accept;
    logic xfer;

    assign accept = bus.in_valid & ~skid_valid_q;
    assign xfer   = main_valid_q & bus.out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        if (xfer) begin
            // in_ready is low whenever the skid is full, so no accept can collide here
            if (skid_valid_q) begin
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_imm_d = dec_imm;
                main_tag_d = bus.in_tag;
                main_err_d = dec_err;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = dec_imm;
                main_tag_d   = bus.in_tag;
                main_err_d   = dec_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec_imm;
                skid_tag_d   = bus.in_tag;
                skid_err_d   = dec_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign bus.in_ready  = ~skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.ImmExt    = main_imm_q;
    assign bus.out_tag   = main_tag_q;
    assign bus.imm_err   = main_err_q;

`ifdef IMM_ERR_COUNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && dec_err && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: 32- and 64-bit instances, backpressure, async reset.
module tb_imm_extend_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    imm_extend_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) if32 ();
    imm_extend_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(5)) if64 ();

`ifdef IMM_ERR_COUNT_EN
    logic [15:0] err_count32;
    logic [15:0] err_count64;
`endif

    imm_extend_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if32)
`ifdef IMM_ERR_COUNT_EN
        ,
        .err_count (err_count32)
`endif
    );

    imm_extend_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if64)
`ifdef IMM_ERR_COUNT_EN
        ,
        .err_count (err_count64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive32(input logic v, input logic [2:0] src, input logic [31:0] ins,
                           input logic [4:0] tag);
        if32.in_valid = v;
        if32.ImmSrc   = src;
        if32.instr    = ins;
        if32.in_tag   = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 32-bit stream: ImmSrc, instr, expected ImmExt, expected imm_err
    logic [2:0]  s32_src [0:9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd5, 3'd0};
    logic [31:0] s32_ins [0:9] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h0010006F,
                                   32'h123452B7, 32'h4030D093, 32'h3400F073, 32'hDEADBEEF,
                                   32'h03F09093, 32'h7FF00093};
    logic [31:0] s32_exp [0:9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                                   32'h12345000, 32'h00000003, 32'h00000001, 32'h00000000,
                                   32'h0000001F, 32'h000007FF};
    logic        s32_err [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic [2:0]  s64_src [0:3] = '{3'd0, 3'd4, 3'd5, 3'd3};
    logic [31:0] s64_ins [0:3] = '{32'hFFF00093, 32'h800002B7, 32'h03F09093, 32'h0010006F};
    logic [63:0] s64_exp [0:3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000,
                                   64'h000000000000003F, 64'h0000000000000800};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive32(1'b0, 3'd0, 32'd0, 5'd0);
        if32.out_ready = 1'b1;
        if64.in_valid  = 1'b0;
        if64.ImmSrc    = 3'd0;
        if64.instr     = 32'd0;
        if64.in_tag    = 5'd0;
        if64.out_ready = 1'b1;

        #3;
        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_in_ready",  64'(if32.in_ready),  64'd1);
        chk("rst_immext",    64'(if32.ImmExt),    64'd0);
        chk("rst_out_tag",   64'(if32.out_tag),   64'd0);
        chk("rst_imm_err",   64'(if32.imm_err),   64'd0);
        #9 rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            drive32(1'b1, s32_src[i], s32_ins[i], 5'(i + 1));
            step();
            chk($sformatf("s32_valid_%0d", i), 64'(if32.out_valid), 64'd1);
            chk($sformatf("s32_imm_%0d", i),   64'(if32.ImmExt),    64'(s32_exp[i]));
            chk($sformatf("s32_tag_%0d", i),   64'(if32.out_tag),   64'(i + 1));
            chk($sformatf("s32_err_%0d", i),   64'(if32.imm_err),   64'(s32_err[i]));
            chk($sformatf("s32_rdy_%0d", i),   64'(if32.in_ready),  64'd1);
        end
        drive32(1'b0, 3'd0, 32'd0, 5'd0);
        step();
        chk("s32_drain", 64'(if32.out_valid), 64'd0);

        for (int i = 0; i < 4; i++) begin
            if64.in_valid = 1'b1;
            if64.ImmSrc   = s64_src[i];
            if64.instr    = s64_ins[i];
            if64.in_tag   = 5'(20 + i);
            step();
            chk($sformatf("s64_valid_%0d", i), 64'(if64.out_valid), 64'd1);
            chk($sformatf("s64_imm_%0d", i),   if64.ImmExt,         s64_exp[i]);
            chk($sformatf("s64_tag_%0d", i),   64'(if64.out_tag),   64'(20 + i));
        end
        if64.in_valid = 1'b0;
        step();
        chk("s64_drain", 64'(if64.out_valid), 64'd0);

        // backpressure: tag 3 must wait upstream until the skid frees
        if32.out_ready = 1'b0;
        drive32(1'b1, 3'd0, 32'h00100093, 5'd1);
        step();
        chk("bp_t1_tag",   64'(if32.out_tag),  64'd1);
        chk("bp_t1_rdy",   64'(if32.in_ready), 64'd1);
        drive32(1'b1, 3'd0, 32'h00200093, 5'd2);
        step();
        chk("bp_t2_rdy",   64'(if32.in_ready), 64'd0);
        chk("bp_t2_tag",   64'(if32.out_tag),  64'd1);
        drive32(1'b1, 3'd0, 32'h00300093, 5'd3);
        step();
        chk("bp_hold_rdy", 64'(if32.in_ready), 64'd0);
        chk("bp_hold_tag", 64'(if32.out_tag),  64'd1);
        chk("bp_hold_imm", 64'(if32.ImmExt),   64'd1);
        chk("bp_hold_vld", 64'(if32.out_valid), 64'd1);
        if32.out_ready = 1'b1;
        step();
        chk("bp_o2_tag",   64'(if32.out_tag),  64'd2);
        chk("bp_o2_imm",   64'(if32.ImmExt),   64'd2);
        chk("bp_o2_rdy",   64'(if32.in_ready), 64'd1);
        step();
        drive32(1'b0, 3'd0, 32'd0, 5'd0);
        chk("bp_o3_tag",   64'(if32.out_tag),   64'd3);
        chk("bp_o3_imm",   64'(if32.ImmExt),    64'd3);
        chk("bp_o3_vld",   64'(if32.out_valid), 64'd1);
        step();
        chk("bp_end_vld",  64'(if32.out_valid), 64'd0);

        // asynchronous reset with both entries occupied
        if32.out_ready = 1'b0;
        drive32(1'b1, 3'd0, 32'h00500093, 5'd5);
        step();
        drive32(1'b1, 3'd0, 32'h00600093, 5'd6);
        step();
        drive32(1'b0, 3'd0, 32'd0, 5'd0);
        chk("mr_full_rdy", 64'(if32.in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_vld",  64'(if32.out_valid), 64'd0);
        chk("mr_rdy",  64'(if32.in_ready),  64'd1);
        chk("mr_imm",  64'(if32.ImmExt),    64'd0);
        chk("mr_tag",  64'(if32.out_tag),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mr_post_vld", 64'(if32.out_valid), 64'd0);
        if32.out_ready = 1'b1;
        drive32(1'b1, 3'd0, 32'h00700093, 5'd7);
        step();
        drive32(1'b0, 3'd0, 32'd0, 5'd0);
        chk("mr_new_tag", 64'(if32.out_tag),   64'd7);
        chk("mr_new_imm", 64'(if32.ImmExt),    64'd7);
        step();
        chk("mr_alone",   64'(if32.out_valid), 64'd0);

`ifdef IMM_ERR_COUNT_EN
        chk("ec_reset", 64'(err_count32), 64'd0);
        if32.out_ready = 1'b0;
        drive32(1'b1, 3'd7, 32'h12345678, 5'd8);
        step();
        drive32(1'b1, 3'd7, 32'h9ABCDEF0, 5'd9);
        step();
        chk("ec_two", 64'(err_count32), 64'd2);
        drive32(1'b1, 3'd7, 32'h0BADF00D, 5'd10);
        step();
        chk("ec_reject", 64'(err_count32), 64'd2);
        drive32(1'b0, 3'd0, 32'd0, 5'd0);
        if32.out_ready = 1'b1;
        step();
        step();
        drive32(1'b1, 3'd7, 32'h0BADF00D, 5'd10);
        step();
        drive32(1'b0, 3'd0, 32'd0, 5'd0);
        chk("ec_three", 64'(err_count32), 64'd3);
        chk("ec_err_out", 64'(if32.imm_err), 64'd1);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate sign-extender.
- Decodes all RV32/RV64 immediate formats: I, S, B, J, U, shift-amount and CSR-uimm.
- Extends the result to DATA_WIDTH and registers it behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between the instruction-fetch/decode register and the execute stage. It carries a sideband tag so that a stalled pipeline loses nothing.

Parameters:
DATA_WIDTH, 32, output immediate width; legal values are 32 or 64 only (elaboration error otherwise).
TAG_WIDTH, 5, width of the sideband tag passed through unchanged (e.g. rd index or ROB id).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  upstream has an instruction.
in_ready  out  1  block can accept this cycle.
ImmSrc  in  3  immediate format select.
instr  in  32  raw instruction word.
in_tag  in  TAG_WIDTH  sideband tag.
out_valid  out  1  ImmExt/out_tag/imm_err valid.
out_ready  in  1  downstream accepts.
ImmExt  out  DATA_WIDTH  extended immediate.
out_tag  out  TAG_WIDTH  tag of the same instruction.
imm_err  out  1  ImmSrc was illegal (111) for this entry.

Behaviour:
- Reset (async assert, sync deassert):
  - out_valid=0, ImmExt=0, out_tag=0, imm_err=0, in_ready=1, skid empty.
- Decode, combinational on input. s = sign-extend from instr[31] to DATA_WIDTH; z = zero-extend.
  - 000 I: s(instr[31:20]).
  - 001 S: s({instr[31:25],instr[11:7]}).
  - 010 B: s({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 011 J: s({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 100 U: s({instr[31:12],12'b0}). For DATA_WIDTH=64, bits 63:32 = instr[31].
  - 101 SHAMT: z(instr[24:20]) when DATA_WIDTH=32; z(instr[25:20]) when DATA_WIDTH=64.
  - 110 CSR uimm: z(instr[19:15]).
  - 111 illegal: ImmExt=0, imm_err=1.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - in_ready is a register output: in_ready = !skid_valid. It carries no combinational path from out_ready.
  - Latency is 1 cycle from acceptance to out_valid when the output stage is empty or draining.
  - Throughput is 1 per cycle while out_ready=1.
- Storage: main output register plus one skid register.
  - Accept while main empty, or main draining this cycle: data goes to main.
  - Accept while main full and not draining: data goes to skid, and in_ready drops next cycle.
  - Transfer with skid full: skid moves to main and skid empties, so in_ready=1 next cycle.
  - Order is strictly FIFO; at most 2 entries are held.
- Simultaneous accept and transfer with skid empty: the new entry replaces main; out_valid stays 1.
- While out_valid=1 and out_ready=0, ImmExt/out_tag/imm_err must hold stable.
- ImmSrc/instr/in_tag are ignored when not accepted; no X propagates to outputs.
- Reset mid-operation: both entries are discarded immediately, and outputs return to reset values asynchronously.

Optional Feature:
Macro IMM_ERR_COUNT_EN.
- Defined:
  - Adds output err_count (16 bits), reset to 0.
  - Increments by 1 on each accepted input with ImmSrc=111.
  - Saturates at 0xFFFF with no wrap.
  - Counts at acceptance, not at output transfer.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- DATA_WIDTH=32, out_ready=1, one instruction per cycle:
  - I 0xFFF00093 -> ImmExt 0xFFFFFFFF.
  - S 0xFE20AE23 -> 0xFFFFFFFC.
  - B 0xFE000CE3 -> 0xFFFFFFF8.
  - J 0x0010006F -> 0x00000800.
  - U 0x123452B7 -> 0x12345000.
  - Each appears on the cycle after acceptance.
- Shift and CSR, DATA_WIDTH=32:
  - SHAMT 0x4030D093 -> 0x00000003.
  - CSR 0x3400F073 -> 0x00000001.
  - ImmSrc=111 with any instr -> ImmExt 0, imm_err=1.
- DATA_WIDTH=64:
  - I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
  - U 0x800002B7 -> 0xFFFFFFFF80000000.
  - SHAMT 0x03F09093 -> 0x000000000000003F.
- Backpressure:
  - Hold out_ready=0 and send tags 1, 2, 3 back-to-back.
  - Required: tags 1 and 2 accepted, in_ready=0 from the cycle after tag 2's acceptance, tag 3 held upstream.
  - Raise out_ready: outputs tags 1, 2, 3 in order with no duplicate or drop.
- Reset mid-operation: with 2 entries held, pull rst_n low -> out_valid=0 and in_ready=1 immediately. After release, the first new accept is output alone.
- With IMM_ERR_COUNT_EN: send 3 accepted ImmSrc=111 inputs, plus 1 offered with in_ready=0 -> err_count=3.
